// File: rtl/arbi_pkg.sv
// Shared defaults and mode encoding for the hold-limited round-robin arbiter.
package arbi_pkg;

    localparam int ARBI_NUM_REQ    = 4;
    localparam int ARBI_DATA_WIDTH = 32;
    localparam int ARBI_MAX_HOLD   = 4;

    typedef enum logic {
        ARBI_FIXED = 1'b0,
        ARBI_RR    = 1'b1
    } arbi_mode_e;

endpackage

// File: rtl/arbi_rr_pick.sv
// Combinational rotating priority picker: first asserted request at or after ptr, wrapping.
module arbi_rr_pick
    import arbi_pkg::*;
#(
    parameter int NUM_REQ = ARBI_NUM_REQ,
    parameter int IDX_W   = $clog2(ARBI_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] k_idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        sum     = '0;
        k_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Modulo by subtraction keeps non-power-of-two counts correct.
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            k_idx = sum[IDX_W-1:0];
            if (!win_vld && req[k_idx]) begin
                win_vld        = 1'b1;
                win_idx        = k_idx;
                win_oh[k_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbi_rr_hold.sv
// N-way arbiter, round-robin or fixed priority, with a bounded grant hold and registered outputs.
module arbi_rr_hold
    import arbi_pkg::*;
#(
    parameter int NUM_REQ    = ARBI_NUM_REQ,
    parameter int DATA_WIDTH = ARBI_DATA_WIDTH,
    parameter int MAX_HOLD   = ARBI_MAX_HOLD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rr_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_valid,
    output logic [DATA_WIDTH-1:0]         arb_out
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HCNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic                  arb_valid_q, arb_valid_d;
    logic [DATA_WIDTH-1:0] arb_out_q, arb_out_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [HCNT_W-1:0]     hold_cnt_q, hold_cnt_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    arbi_mode_e            mode;
    logic [IDX_W-1:0]      pick_ptr;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  hold_ok;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Fixed priority is the rotating picker with its start pinned at index 0.
    always_comb begin
        mode     = rr_en ? ARBI_RR : ARBI_FIXED;
        pick_ptr = (mode == ARBI_RR) ? ptr_q : '0;
    end

    arbi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    always_comb begin
        hold_ok     = arb_valid_q && req[grant_id_q] && (hold_cnt_q < HOLD_LIM);
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        arb_valid_d = arb_valid_q;
        arb_out_d   = arb_out_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        if (hold_ok) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            arb_out_d  = data_arr[grant_id_q];
        end else if (pick_vld) begin
            grant_d     = pick_oh;
            grant_id_d  = pick_idx;
            arb_valid_d = 1'b1;
            arb_out_d   = data_arr[pick_idx];
            hold_cnt_d  = '0;
            ptr_d       = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end else begin
            // Idle: grant_id keeps the last holder for observability.
            grant_d     = '0;
            arb_valid_d = 1'b0;
            arb_out_d   = '0;
            hold_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            grant_id_q  <= '0;
            arb_valid_q <= 1'b0;
            arb_out_q   <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            arb_valid_q <= arb_valid_d;
            arb_out_q   <= arb_out_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign arb_valid = arb_valid_q;
    assign arb_out   = arb_out_q;

endmodule

// File: doc/arbi_rr_hold.md
Name: arbi_rr_hold

Overview:
- NUM_REQ-way arbiter that generalises the two-master, 32-bit arbiter to any requester count and data width.
- Mode is selectable at run time: round-robin or fixed priority.
- A granted requester may hold the bus for up to MAX_HOLD consecutive cycles before re-arbitration is forced.
- Sits between bus masters and a shared slave path. Grant, grant index and muxed data are all registered.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, width of each requester's data word and of arb_out.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (>=1; 1 = re-arbitrate every cycle).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rr_en  in  1  1 = round-robin, 0 = fixed priority (index 0 highest).
- req  in  NUM_REQ  request vector, bit i = requester i.
- data_in  in  NUM_REQ*DATA_WIDTH  flattened data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  NUM_REQ  registered one-hot grant (all-zero when idle).
- grant_id  out  $clog2(NUM_REQ)  registered index of granted requester.
- arb_valid  out  1  registered, = |grant.
- arb_out  out  DATA_WIDTH  registered data of granted requester.

Behaviour:
- Reset (sync, active-high):
  - grant=0, grant_id=0, arb_valid=0, arb_out=0.
  - RR pointer=0 (requester 0 highest priority), hold_cnt=0.
  - Reset overrides everything, including a grant in progress.
- Latency: req/data_in sampled at edge N appear in grant/grant_id/arb_out at edge N (registered). Visible to masters one cycle after they were driven.
- Hold/keep:
  - Condition: current holder h still has req[h]=1 and hold_cnt < MAX_HOLD-1.
  - Effect: grant stays on h, hold_cnt increments, arb_out <= data_in[h] (data tracks holder every cycle).
- Arbitration occurs when any of these is true:
  - no current grant;
  - holder dropped req;
  - hold_cnt == MAX_HOLD-1 (hold limit).
- Arbitration result:
  - Winner chosen from req; hold_cnt <= 0.
  - If req==0: grant=0, arb_valid=0, arb_out=0, grant_id keeps its last value.
- Fixed priority (rr_en=0): lowest asserted index wins.
- Round-robin (rr_en=1):
  - Search starts at pointer, wraps modulo NUM_REQ; first asserted bit wins.
  - On every new grant to w (either mode), pointer <= (w+1) mod NUM_REQ.
- Hold-limit expiry: previous holder is a normal candidate.
  - RR: the search starts after it, so it wins only if it is the sole requester. It is then re-granted with hold_cnt restarted at 0, and grant stays high with no bubble.
  - Fixed mode: the lowest index wins again.
- rr_en changes take effect at the next arbitration decision, never mid-hold.
- Grant is always one-hot or zero; grant_id always equals the index of the set bit while arb_valid=1.
- hold_cnt width is $clog2(MAX_HOLD)+1. It never exceeds MAX_HOLD-1.

Decomposition:
- Package arbi_pkg holds:
  - default parameter constants (ARBI_NUM_REQ, ARBI_DATA_WIDTH, ARBI_MAX_HOLD);
  - typedef arbi_mode_e {ARBI_FIXED, ARBI_RR}.
- One combinational sub-module, arbi_rr_pick:
  - inputs: req vector, start pointer;
  - outputs: one-hot winner, winner index, any-valid.
  - Fixed mode is produced by driving pointer=0.
- The top holds pointer, hold_cnt and the output registers.

Test Plan (NUM_REQ=4, DATA_WIDTH=32, MAX_HOLD=4):
- Reset mid-grant:
  - stimulus: req=4'b0010 held 2 cycles, then assert reset for 1 cycle;
  - response: next edge grant=0, arb_valid=0, arb_out=0; after release the next grant follows pointer=0 priority.
- Fixed priority:
  - stimulus: rr_en=0, req=4'b1110, data_in slices i=32'hA0+i;
  - response: grant=4'b0010, grant_id=1, arb_out=32'hA1. After 4 cycles the hold expires and requester 1 is re-granted (hold_cnt restarts, no idle cycle).
- Round-robin rotation:
  - stimulus: rr_en=1, req=4'b1111, MAX_HOLD forced by a 1-cycle req drop pattern;
  - response: grants cycle 0,1,2,3,0 in successive arbitrations; arb_out tracks each slice.
- Hold limit:
  - stimulus: rr_en=1, req=4'b0011 constant;
  - response: grant 4'b0001 for exactly 4 cycles, then 4'b0010 for 4 cycles, alternating; arb_valid stays 1 throughout.
- Early release:
  - stimulus: holder 2 drops req after 2 cycles while req[3]=1;
  - response: next edge grant=4'b1000, grant_id=3, pointer=0.
- Idle and sole requester wrap:
  - stimulus: req=0 -> arb_valid=0, arb_out=0, grant_id retains last;
  - stimulus: then req=4'b1000 only, rr_en=1 with pointer=0 -> grant=4'b1000 (wrap search). The holder is re-granted every 4 cycles with no bubble.
